// File: rtl/conv_sequencer.sv
// Control sequencer for the 3x3 convolution datapath: primes the line buffer, walks the
// kernel window across the image at the latched stride, and reports each finished output.
module conv_sequencer #(
    parameter  int IMG_W = 8,
    parameter  int IMG_H = 8,
    localparam int CW    = ($clog2(IMG_W) < 1) ? 1 : $clog2(IMG_W),
    localparam int RW    = ($clog2(IMG_H) < 1) ? 1 : $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    stride,
    input  logic          abort,
    input  logic          buf_ready,
    output logic          busy,
    output logic          done,
    output logic          shift_buffer,
    output logic [3:0]    kernel_addr,
    output logic [1:0]    win_row,
    output logic [CW-1:0] win_col,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          out_valid,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WAIT_BUF,
        TAP,
        DRAIN,
        DONE
    } state_t;

    // Output grid size for each legal stride; trailing partial windows are skipped.
    localparam int OW1 = (IMG_W - 3) / 1 + 1;
    localparam int OW2 = (IMG_W - 3) / 2 + 1;
    localparam int OW3 = (IMG_W - 3) / 3 + 1;
    localparam int OH1 = (IMG_H - 3) / 1 + 1;
    localparam int OH2 = (IMG_H - 3) / 2 + 1;
    localparam int OH3 = (IMG_H - 3) / 3 + 1;

    state_t        state_q, state_d;
    logic [1:0]    stride_q;
    logic [1:0]    shift_cnt;
    logic [3:0]    tap;
    logic [CW-1:0] col_base;
    logic [CW-1:0] col_idx;
    logic [RW-1:0] row_idx;
    logic [RW-1:0] out_row_q;
    logic [CW-1:0] out_col_q;

    logic [CW-1:0] last_col;
    logic [RW-1:0] last_row;
    logic          col_done;
    logic          row_done;
    logic [1:0]    tap_row;
    logic [1:0]    tap_col;
    logic          in_tap;
    logic          cancel;

    always_comb begin
        case (stride_q)
            2'd2: begin
                last_col = CW'(OW2 - 1);
                last_row = RW'(OH2 - 1);
            end
            2'd3: begin
                last_col = CW'(OW3 - 1);
                last_row = RW'(OH3 - 1);
            end
            default: begin
                last_col = CW'(OW1 - 1);
                last_row = RW'(OH1 - 1);
            end
        endcase
    end

    assign col_done = (col_idx == last_col);
    assign row_done = (row_idx == last_row);
    assign cancel   = abort && (state_q != IDLE);

    // Row-major tap split without a divider: tap_row = tap / 3, tap_col = tap % 3.
    always_comb begin
        tap_row = 2'd0;
        tap_col = 2'(tap);
        if (tap >= 4'd6) begin
            tap_row = 2'd2;
            tap_col = 2'(tap - 4'd6);
        end else if (tap >= 4'd3) begin
            tap_row = 2'd1;
            tap_col = 2'(tap - 4'd3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = SHIFT;
            SHIFT:    state_d = WAIT_BUF;
            WAIT_BUF: if (buf_ready) state_d = (shift_cnt == 2'd1) ? TAP : SHIFT;
            TAP:      if (tap == 4'd8) state_d = DRAIN;
            DRAIN: begin
                if (!col_done)      state_d = TAP;
                else if (!row_done) state_d = SHIFT;
                else                state_d = DONE;
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (cancel) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stride_q  <= 2'd0;
            shift_cnt <= 2'd0;
            tap       <= 4'd0;
            col_base  <= '0;
            col_idx   <= '0;
            row_idx   <= '0;
            out_row_q <= '0;
            out_col_q <= '0;
        end else if (cancel) begin
            shift_cnt <= 2'd0;
            tap       <= 4'd0;
            col_base  <= '0;
            col_idx   <= '0;
            row_idx   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        stride_q  <= (stride == 2'd0) ? 2'd1 : stride;
                        shift_cnt <= 2'd3;
                        tap       <= 4'd0;
                        col_base  <= '0;
                        col_idx   <= '0;
                        row_idx   <= '0;
                    end
                end
                WAIT_BUF: begin
                    if (buf_ready) shift_cnt <= shift_cnt - 2'd1;
                end
                TAP: begin
                    if (tap == 4'd8) begin
                        tap       <= 4'd0;
                        out_row_q <= row_idx;
                        out_col_q <= col_idx;
                    end else begin
                        tap <= tap + 4'd1;
                    end
                end
                DRAIN: begin
                    if (!col_done) begin
                        col_base <= col_base + CW'(stride_q);
                        col_idx  <= col_idx + CW'(1);
                    end else if (!row_done) begin
                        col_base  <= '0;
                        col_idx   <= '0;
                        row_idx   <= row_idx + RW'(1);
                        shift_cnt <= stride_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_tap       = (state_q == TAP);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign shift_buffer = (state_q == SHIFT);
    assign mac_en       = in_tap;
    assign mac_clr      = in_tap && (tap == 4'd0);
    assign kernel_addr  = in_tap ? tap : 4'd0;
    assign win_row      = in_tap ? tap_row : 2'd0;
    assign win_col      = in_tap ? (col_base + CW'(tap_col)) : '0;
    assign out_valid    = (state_q == DRAIN);
    assign out_row      = out_row_q;
    assign out_col      = out_col_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: a per-cycle expected trace is built from the window-walk
// rules (shift pairs, 9 taps + drain per output) and compared against the DUT every cycle.
module tb_conv_sequencer;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int CW = ($clog2(W) < 1) ? 1 : $clog2(W);
    localparam int RW = ($clog2(H) < 1) ? 1 : $clog2(H);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    stride;
    logic          abort;
    logic          buf_ready;
    logic          busy;
    logic          done;
    logic          shift_buffer;
    logic [3:0]    kernel_addr;
    logic [1:0]    win_row;
    logic [CW-1:0] win_col;
    logic          mac_clr;
    logic          mac_en;
    logic          out_valid;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;

    conv_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stride       (stride),
        .abort        (abort),
        .buf_ready    (buf_ready),
        .busy         (busy),
        .done         (done),
        .shift_buffer (shift_buffer),
        .kernel_addr  (kernel_addr),
        .win_row      (win_row),
        .win_col      (win_col),
        .mac_clr      (mac_clr),
        .mac_en       (mac_en),
        .out_valid    (out_valid),
        .out_row      (out_row),
        .out_col      (out_col)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          shift;
        logic          clr;
        logic          en;
        logic          valid;
        logic [3:0]    kaddr;
        logic [1:0]    wrow;
        logic [CW-1:0] wcol;
        logic [RW-1:0] orow;
        logic [CW-1:0] ocol;
    } obs_t;

    int            n_assert = 0;
    int            n_fail   = 0;
    obs_t          exp_q[$];
    bit            wait_q[$];
    logic [RW-1:0] held_row;
    logic [CW-1:0] held_col;

    function automatic obs_t sample();
        obs_t o;
        o.busy  = busy;
        o.done  = done;
        o.shift = shift_buffer;
        o.clr   = mac_clr;
        o.en    = mac_en;
        o.valid = out_valid;
        o.kaddr = kernel_addr;
        o.wrow  = win_row;
        o.wcol  = win_col;
        o.orow  = out_row;
        o.ocol  = out_col;
        return o;
    endfunction

    function automatic obs_t idle_exp();
        obs_t o = '0;
        o.orow = held_row;
        o.ocol = held_col;
        return o;
    endfunction

    task automatic check(input string tag, input int cyc, input obs_t got, input obs_t want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, got, want);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // Reference schedule: per output row, shift in 3 rows (first) or S rows, each shift
    // being a request cycle plus a wait cycle; then per window 9 taps and one drain.
    function automatic void build(input int s);
        int            ow = (W - 3) / s + 1;
        int            oh = (H - 3) / s + 1;
        logic [RW-1:0] hr = held_row;
        logic [CW-1:0] hc = held_col;
        obs_t          o;
        exp_q.delete();
        wait_q.delete();
        for (int r = 0; r < oh; r++) begin
            for (int n = 0; n < ((r == 0) ? 3 : s); n++) begin
                o = '0; o.busy = 1'b1; o.orow = hr; o.ocol = hc; o.shift = 1'b1;
                exp_q.push_back(o); wait_q.push_back(1'b0);
                o.shift = 1'b0;
                exp_q.push_back(o); wait_q.push_back(1'b1);
            end
            for (int c = 0; c < ow; c++) begin
                for (int k = 0; k < 9; k++) begin
                    o = '0; o.busy = 1'b1; o.orow = hr; o.ocol = hc;
                    o.en = 1'b1; o.clr = (k == 0);
                    o.kaddr = 4'(k); o.wrow = 2'(k / 3); o.wcol = CW'(c * s + k % 3);
                    exp_q.push_back(o); wait_q.push_back(1'b0);
                end
                hr = RW'(r); hc = CW'(c);
                o = '0; o.busy = 1'b1; o.valid = 1'b1; o.orow = hr; o.ocol = hc;
                exp_q.push_back(o); wait_q.push_back(1'b0);
            end
        end
        o = '0; o.busy = 1'b1; o.done = 1'b1; o.orow = hr; o.ocol = hc;
        exp_q.push_back(o); wait_q.push_back(1'b0);
    endfunction

    // mode: 0 = buf_ready tied high, 1 = random buf_ready, 2 = low during cycles 4..8.
    // glitch/abort/rst cycle numbers of 0 mean "not used"; cycle 1 is the first SHIFT.
    task automatic run_pass(input logic [1:0] s_in, input int mode, input int glitch_cyc,
                            input int abort_cyc, input int rst_cyc, output int done_cyc,
                            output int n_valid, output int n_shift, output int n_stall);
        int   s = (s_in == 2'd0) ? 1 : int'(s_in);
        int   idx = 0;
        int   cyc = 0;
        bit   br;
        bit   stop = 1'b0;
        obs_t got;
        done_cyc = 0; n_valid = 0; n_shift = 0; n_stall = 0;
        build(s);
        @(negedge clk);
        start = 1'b1; stride = s_in; abort = 1'b0;
        while (!stop) begin
            @(negedge clk);
            cyc++;
            got = sample();
            check("trace", cyc, got, exp_q[idx]);
            held_row = exp_q[idx].orow;
            held_col = exp_q[idx].ocol;
            if (got.valid) n_valid++;
            if (got.shift) n_shift++;
            if (got.done)  done_cyc = cyc;
            start = (cyc == glitch_cyc);
            case (mode)
                0:       br = 1'b1;
                1:       br = ($urandom_range(3) != 0);
                default: br = !(cyc >= 4 && cyc <= 8);
            endcase
            buf_ready = br;
            if (wait_q[idx] && !br) n_stall++;
            else idx++;
            if (cyc == abort_cyc) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_idle", cyc + 1, sample(), idle_exp());
                stop = 1'b1;
            end else if (cyc == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                check("rst_async", cyc, sample(), '0);
                held_row = '0;
                held_col = '0;
                @(negedge clk);
                check("rst_hold", cyc + 1, sample(), '0);
                rst_n = 1'b1;
                stop = 1'b1;
            end else if (idx == exp_q.size()) begin
                @(negedge clk);
                check("idle_after", cyc + 1, sample(), idle_exp());
                stop = 1'b1;
            end else if (cyc >= 20000) begin
                check_int("timeout", cyc, 0);
                stop = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int d, v, sh, st;
        int s, ow, oh;
        logic [1:0] s_rand;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; stride = 2'd0; buf_ready = 1'b1;
        held_row = '0; held_col = '0;
        #12;
        check("reset", 0, sample(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 0, sample(), '0);

        run_pass(2'd1, 0, 0, 0, 0, d, v, sh, st);
        check_int("s1_done_cycle", d, 377);
        check_int("s1_valid_count", v, 36);
        check_int("s1_shift_count", sh, 8);

        run_pass(2'd2, 0, 0, 0, 0, d, v, sh, st);
        check_int("s2_done_cycle", d, 105);
        check_int("s2_valid_count", v, 9);
        check_int("s2_shift_count", sh, 7);

        run_pass(2'd3, 0, 0, 0, 0, d, v, sh, st);
        check_int("s3_done_cycle", d, 53);
        check_int("s3_valid_count", v, 4);

        run_pass(2'd0, 0, 0, 0, 0, d, v, sh, st);
        check_int("s0_done_cycle", d, 377);
        check_int("s0_valid_count", v, 36);

        run_pass(2'd1, 2, 0, 0, 0, d, v, sh, st);
        check_int("stall_cycles", st, 5);
        check_int("stall_done_cycle", d, 382);

        run_pass(2'd1, 0, 20, 50, 0, d, v, sh, st);
        check_int("abort_no_done", d, 0);
        check_int("abort_valid_count", v, 4);
        run_pass(2'd1, 0, 0, 0, 0, d, v, sh, st);
        check_int("after_abort_done_cycle", d, 377);

        run_pass(2'd1, 0, 0, 0, 30, d, v, sh, st);
        check_int("reset_no_done", d, 0);
        run_pass(2'd1, 0, 0, 0, 0, d, v, sh, st);
        check_int("after_reset_done_cycle", d, 377);

        for (int i = 0; i < 4; i++) begin
            s_rand = 2'($urandom_range(3));
            s  = (s_rand == 2'd0) ? 1 : int'(s_rand);
            ow = (W - 3) / s + 1;
            oh = (H - 3) / s + 1;
            run_pass(s_rand, 1, 0, 0, 0, d, v, sh, st);
            check_int("rand_done_cycle", d, 6 + 10 * ow * oh + 2 * s * (oh - 1) + 1 + st);
            check_int("rand_valid_count", v, ow * oh);
            check_int("rand_shift_count", sh, 3 + s * (oh - 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Control sequencer for the 3x3 convolution datapath: walks the kernel window across an IMG_W x IMG_H image held in the three-line buffer, honouring a 1-3 pixel stride. It drives kernel tap addresses, line/column selects, MAC clear/enable, line-buffer shift requests with a ready handshake, and per-output valid/coordinates, then pulses done. It sits between the top-level start/stride control and the line-buffer + kernel ROM + MAC datapath.

## Interface
- IMG_W, 8, image width in pixels (3..256)
- IMG_H, 8, image height in pixels (3..256)
- CW, derived = max(1, ceil(log2(IMG_W))); RW, derived = max(1, ceil(log2(IMG_H)))
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled only in IDLE
- stride  in  2  window step; latched on accepted start; 0 treated as 1
- abort  in  1  synchronous cancel, returns to IDLE without done
- buf_ready  in  1  line buffer has completed the last requested shift
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- shift_buffer  out  1  one-cycle request to shift one new image row into the line buffer
- kernel_addr  out  4  tap index 0..8, row-major
- win_row  out  2  line select = kernel_addr / 3
- win_col  out  CW  column select = col_base + kernel_addr % 3
- mac_clr  out  1  clear accumulator (first tap)
- mac_en  out  1  accumulate this tap
- out_valid  out  1  one-cycle pulse: accumulator holds a finished output
- out_row  out  RW  output row index of the pulsed result
- out_col  out  CW  output column index of the pulsed result

## Operation
- Output size: OW = (IMG_W-3)/S + 1, OH = (IMG_H-3)/S + 1 (integer divide, S = effective stride). Trailing columns/rows not covered by a full window are skipped.
- States: IDLE, SHIFT, WAIT_BUF, TAP, DRAIN, DONE.
- IDLE: start=1 -> latch S, clear col_base/row counters, load shift count 3 (prime), go SHIFT. start while busy ignored.
- SHIFT: shift_buffer=1 for exactly this cycle, go WAIT_BUF.
- WAIT_BUF: hold until buf_ready=1 sampled; then decrement shift count; if nonzero go SHIFT, else go TAP. buf_ready low holds indefinitely with all outputs stable.
- TAP: 9 cycles, kernel_addr 0..8; mac_en=1 every cycle, mac_clr=1 only at kernel_addr=0; then DRAIN.
- DRAIN: out_valid=1 with out_row/out_col of the window just computed. Next: more columns -> col_base += S, TAP; last column, more rows -> col_base=0, shift count = S, SHIFT; last output -> DONE.
- DONE: done=1 one cycle, go IDLE.
- abort=1 in any non-IDLE state: next state IDLE, no done, no out_valid that cycle; counters cleared.
- rst_n low (any time, including mid-run): immediately IDLE, all outputs 0, counters 0.

## Timing
- Reset values: every output 0 (busy, done, shift_buffer, kernel_addr, win_row, win_col, mac_clr, mac_en, out_valid, out_row, out_col).
- All outputs registered/state-decoded; no combinational path from buf_ready, start or abort to any output.
- First SHIFT cycle is the cycle after the edge sampling start.
- With buf_ready tied 1: each shift costs 2 cycles; each output costs 10 (9 TAP + 1 DRAIN).
- Total cycles from first SHIFT through DONE inclusive = 6 + 10*OW*OH + 2*S*(OH-1) + 1.
- kernel_addr, win_row, win_col, mac_* are 0 outside TAP; out_row/out_col hold last value outside DRAIN.

## Test plan
- 8x8, stride=1, buf_ready=1: 3 priming shift pulses, 36 out_valid pulses (rows/cols 0..5 raster order), 5 further single shifts, done in cycle 377; busy low after.
- 8x8, stride=2: 9 outputs, out_col sequence 0,1,2 per row, win_col in second window = 2..4, pairs of shifts between rows, done in cycle 105.
- 8x8, stride=3 then stride=0: 4 outputs / done at cycle 53; stride=0 run identical to stride=1 (377).
- buf_ready held low 5 cycles after second priming shift: FSM stays WAIT_BUF, outputs frozen, done delayed exactly 5 cycles.
- start pulsed mid-run and abort at cycle 50: start ignored; abort -> IDLE next cycle, no done; fresh start then completes normally.
- rst_n low for 1 cycle mid-TAP: all outputs 0 asynchronously, IDLE; subsequent start runs a full 377-cycle pass.
